gpu_ctrl_regbank: RTL and testbench

Parametrised AXI4-Lite slave register bank for the GPU controller. It replaces the fixed four-register slave with a configurable bank that adds:
- a configurable register count and data width;
- per-register read-only status inputs;
- byte-strobe writes;
- per-register write-pulse outputs;
- SLVERR responses for bad accesses.

It sits between the CPU AXI interconnect and the GPU draw engine. Software writes control words; the engine reads `reg_out` and reports back through `status_in`.

---
 rtl/gpu_ctrl_regbank.sv | 141 ++++++++++++++
 tb/tb_gpu_ctrl_regbank.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_ctrl_regbank.sv
// AXI4-Lite register bank: byte-strobed RW registers, RO status registers, per-register write pulses.
// Write commits one cycle after both AW and W are held; read data one cycle after AR; READY drops while B/R is outstanding.
module gpu_ctrl_regbank #(
  parameter int                  C_S_AXI_DATA_WIDTH = 32,
  parameter int                  C_S_AXI_ADDR_WIDTH = 8,
  parameter int                  NUM_REGS           = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK            = '0
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS-1:0]                    wr_pulse
);

  localparam int DW   = C_S_AXI_DATA_WIDTH;
  localparam int AW   = C_S_AXI_ADDR_WIDTH;
  localparam int NB   = DW / 8;
  localparam int OFFW = $clog2(NB);
  localparam int IDXW = AW - OFFW;
  localparam int RW   = $clog2(NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic            rst_done;
  logic            aw_full, w_full;
  logic [IDXW-1:0] aw_idx;
  logic [DW-1:0]   w_data;
  logic [NB-1:0]   w_strb;
  logic [DW-1:0]   regs [NUM_REGS];
  logic [DW-1:0]   stat [NUM_REGS];

  logic            aw_hs, w_hs, ar_hs, commit, w_ok, ar_ok;
  logic [IDXW-1:0] ar_idx;
  logic [RW-1:0]   w_sel, r_sel;
  logic            unused;

  assign S_AXI_AWREADY = rst_done & ~aw_full & ~S_AXI_BVALID;
  assign S_AXI_WREADY  = rst_done & ~w_full & ~S_AXI_BVALID;
  assign S_AXI_ARREADY = rst_done & ~S_AXI_RVALID;

  assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
  assign commit = aw_full & w_full;

  assign ar_idx = S_AXI_ARADDR[AW-1:OFFW];
  assign w_sel  = aw_idx[RW-1:0];
  assign r_sel  = ar_idx[RW-1:0];
  assign w_ok   = (32'(aw_idx) < NUM_REGS) && !RO_MASK[w_sel];
  assign ar_ok  = (32'(ar_idx) < NUM_REGS);

  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[OFFW-1:0], S_AXI_ARADDR[OFFW-1:0]};

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_map
    assign stat[i]              = status_in[i*DW +: DW];
    assign reg_out[i*DW +: DW]  = RO_MASK[i] ? '0 : regs[i];
  end

  // Write path: one-entry AW and W holders, commit once both are present.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      rst_done     <= 1'b0;
      aw_full      <= 1'b0;
      w_full       <= 1'b0;
      aw_idx       <= '0;
      w_data       <= '0;
      w_strb       <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
      wr_pulse     <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      rst_done <= 1'b1;
      wr_pulse <= '0;
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[AW-1:OFFW];
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (S_AXI_BVALID && S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
      if (commit) begin
        aw_full      <= 1'b0;
        w_full       <= 1'b0;
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= w_ok ? RESP_OKAY : RESP_SLVERR;
        if (w_ok) begin
          wr_pulse[w_sel] <= 1'b1;
          for (int b = 0; b < NB; b++)
            if (w_strb[b]) regs[w_sel][b*8 +: 8] <= w_data[b*8 +: 8];
        end
      end
    end
  end

  // Read path samples regs before any same-edge commit lands.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
    end else begin
      if (S_AXI_RVALID && S_AXI_RREADY) S_AXI_RVALID <= 1'b0;
      if (ar_hs) begin
        S_AXI_RVALID <= 1'b1;
        if (!ar_ok) begin
          S_AXI_RDATA <= '0;
          S_AXI_RRESP <= RESP_SLVERR;
        end else begin
          S_AXI_RRESP <= RESP_OKAY;
          S_AXI_RDATA <= RO_MASK[r_sel] ? stat[r_sel] : regs[r_sel];
        end
      end
    end
  end

endmodule

// File: tb/tb_gpu_ctrl_regbank.sv
// Bench for gpu_ctrl_regbank: a 32-bit/16-register bank with register 3 read-only, plus a 64-bit/4-register bank.
module tb_gpu_ctrl_regbank;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]   prot = 3'b000;

  // 32-bit bank
  logic [7:0]   awaddr = '0, araddr = '0;
  logic         awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [31:0]  wdata = '0, rdata;
  logic [3:0]   wstrb = '0;
  logic [1:0]   bresp, rresp;
  logic [511:0] reg_out, status_in;
  logic [15:0]  wr_pulse;

  // 64-bit bank
  logic [7:0]   awaddr64 = '0, araddr64 = '0;
  logic         awvalid64 = 0, wvalid64 = 0, bready64 = 0, arvalid64 = 0, rready64 = 0;
  logic         awready64, wready64, bvalid64, arready64, rvalid64;
  logic [63:0]  wdata64 = '0, rdata64;
  logic [7:0]   wstrb64 = '0;
  logic [1:0]   bresp64, rresp64;
  logic [255:0] reg_out64;
  logic [255:0] status64 = '0;
  logic [3:0]   pulse64;

  // Reference model
  logic [31:0]  mdl [16];
  logic [31:0]  stat_m [16];
  logic [15:0]  ro_m = 16'h0008;
  int           npass = 0, nchk = 0;

  always_comb begin
    status_in = '0;
    for (int i = 0; i < 16; i++) status_in[i*32 +: 32] = stat_m[i];
  end

  gpu_ctrl_regbank #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(8), .NUM_REGS(16), .RO_MASK(16'h0008)) u0 (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(prot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(prot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .status_in(status_in), .wr_pulse(wr_pulse));

  gpu_ctrl_regbank #(.C_S_AXI_DATA_WIDTH(64), .C_S_AXI_ADDR_WIDTH(8), .NUM_REGS(4), .RO_MASK(4'h0)) u1 (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr64), .S_AXI_AWPROT(prot), .S_AXI_AWVALID(awvalid64), .S_AXI_AWREADY(awready64),
    .S_AXI_WDATA(wdata64), .S_AXI_WSTRB(wstrb64), .S_AXI_WVALID(wvalid64), .S_AXI_WREADY(wready64),
    .S_AXI_BRESP(bresp64), .S_AXI_BVALID(bvalid64), .S_AXI_BREADY(bready64),
    .S_AXI_ARADDR(araddr64), .S_AXI_ARPROT(prot), .S_AXI_ARVALID(arvalid64), .S_AXI_ARREADY(arready64),
    .S_AXI_RDATA(rdata64), .S_AXI_RRESP(rresp64), .S_AXI_RVALID(rvalid64), .S_AXI_RREADY(rready64),
    .reg_out(reg_out64), .status_in(status64), .wr_pulse(pulse64));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [511:0] exp_flat();
    logic [511:0] f;
    f = '0;
    for (int i = 0; i < 16; i++) f[i*32 +: 32] = ro_m[i] ? 32'h0 : mdl[i];
    return f;
  endfunction

  // W handshake may lead or trail AW by the given cycle offsets.
  task automatic wr32(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int awd, input int wd);
    int c, idx;
    bit ad, wdn, ah, wh, ok;
    logic [15:0] ep;
    idx = int'(a >> 2);
    ok = 1'b0;
    if (idx < 16) ok = !ro_m[idx];
    ep = '0;
    if (ok) ep[idx] = 1'b1;
    ad = 0; wdn = 0; c = 0;
    while (!(ad && wdn) && c < 50) begin
      if (!ad && c >= awd) begin awaddr = a; awvalid = 1'b1; end
      if (!wdn && c >= wd) begin wdata = d; wstrb = s; wvalid = 1'b1; end
      ah = awvalid && awready;
      wh = wvalid && wready;
      tick();
      c++;
      if (ah) begin ad = 1; awvalid = 1'b0; end
      if (wh) begin wdn = 1; wvalid = 1'b0; end
    end
    check("wr_handshake", ad && wdn, 1);
    check("wr_bvalid_early", bvalid, 0);
    tick();
    check("wr_bvalid", bvalid, 1);
    check("wr_bresp", bresp, ok ? 2'b00 : 2'b10);
    check("wr_pulse", wr_pulse, ep);
    if (ok)
      for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("wr_bclear", bvalid, 0);
    check("wr_pulse_clear", wr_pulse, 0);
    check("reg_out_eq", reg_out === exp_flat(), 1);
  endtask

  task automatic rd32(input logic [7:0] a);
    int n, idx;
    bit hs;
    logic [31:0] ed;
    logic [1:0] er;
    idx = int'(a >> 2);
    if (idx >= 16) begin ed = 32'h0; er = 2'b10; end
    else if (ro_m[idx]) begin ed = stat_m[idx]; er = 2'b00; end
    else begin ed = mdl[idx]; er = 2'b00; end
    araddr = a;
    arvalid = 1'b1;
    n = 0;
    do begin hs = arready; tick(); n++; end while (!hs && n < 20);
    arvalid = 1'b0;
    check("rd_rvalid", rvalid, 1);
    check("rd_rdata", rdata, ed);
    check("rd_rresp", rresp, er);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("rd_rclear", rvalid, 0);
  endtask

  task automatic wr64(input logic [7:0] a, input logic [63:0] d);
    int n;
    bit ah, wh, ad, wdn;
    awaddr64 = a; wdata64 = d; wstrb64 = 8'hFF;
    awvalid64 = 1'b1; wvalid64 = 1'b1;
    ad = 0; wdn = 0; n = 0;
    while (!(ad && wdn) && n < 20) begin
      ah = awvalid64 && awready64;
      wh = wvalid64 && wready64;
      tick();
      n++;
      if (ah) begin ad = 1; awvalid64 = 1'b0; end
      if (wh) begin wdn = 1; wvalid64 = 1'b0; end
    end
    tick();
    check("wr64_bvalid", bvalid64, 1);
    check("wr64_bresp", bresp64, 2'b00);
    bready64 = 1'b1;
    tick();
    bready64 = 1'b0;
  endtask

  task automatic rd64(input logic [7:0] a, input logic [63:0] ed);
    int n;
    bit hs;
    araddr64 = a;
    arvalid64 = 1'b1;
    n = 0;
    do begin hs = arready64; tick(); n++; end while (!hs && n < 20);
    arvalid64 = 1'b0;
    check("rd64_rvalid", rvalid64, 1);
    check("rd64_rdata", rdata64, ed);
    check("rd64_rresp", rresp64, 2'b00);
    rready64 = 1'b1;
    tick();
    rready64 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old5;
    bit seen;
    for (int i = 0; i < 16; i++) begin
      mdl[i] = '0;
      stat_m[i] = $urandom;
    end
    stat_m[3] = 32'hCAFE0003;

    // Reset behaviour
    #200;
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    check("rst_reg_out", reg_out, 512'h0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_pulse", wr_pulse, 0);
    check("rst_rdata", rdata, 0);
    check("rst_ready64", {awready64, wready64, arready64}, 3'b000);
    tick();
    rst = 1'b0;
    check("rel_ready_low", {awready, wready, arready}, 3'b000);
    tick();
    check("rel_ready_high", {awready, wready, arready}, 3'b111);
    check("rel_ready64_high", {awready64, wready64, arready64}, 3'b111);

    // Strobed write with W leading AW by 3 cycles
    wr32(8'h08, 32'hAABBCCDD, 4'b0101, 3, 0);
    check("strobe_reg2", reg_out[95:64], 32'h00BB00DD);

    // Sequential fill and readback (register 3 is read-only)
    for (int i = 0; i < 16; i++) wr32(8'(i * 4), 32'(i + 1), 4'hF, 0, 0);
    for (int i = 0; i < 16; i++) rd32(8'(i * 4));

    // Read-only and out-of-range accesses
    wr32(8'h0C, 32'h00001234, 4'hF, 0, 0);
    rd32(8'h0C);
    wr32(8'h40, 32'hDEADBEEF, 4'hF, 0, 0);
    rd32(8'h40);
    wr32(8'h08, 32'h11223344, 4'h0, 1, 0);

    // Read captured on the same edge as a commit to the same register
    old5 = mdl[5];
    awaddr = 8'h14; wdata = 32'h5A5A1234; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    check("race_ready", {awready, wready}, 2'b11);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 8'h14; arvalid = 1'b1;
    check("race_arready", arready, 1);
    tick();
    arvalid = 1'b0;
    check("race_rdata_old", rdata, old5);
    check("race_bvalid", bvalid, 1);
    check("race_pulse", wr_pulse, 16'h0020);
    mdl[5] = 32'h5A5A1234;
    rready = 1'b1; bready = 1'b1;
    tick();
    rready = 1'b0; bready = 1'b0;
    check("race_reg_out", reg_out === exp_flat(), 1);

    // Randomized mix of reads and writes
    for (int k = 0; k < 40; k++) begin
      logic [7:0] a;
      a = 8'(($urandom_range(0, 17) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        wr32(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        rd32(a);
    end

    // 64-bit bank
    wr64(8'h18, 64'h0123456789ABCDEF);
    check("b64_reg3", reg_out64[255:192], 64'h0123456789ABCDEF);
    rd64(8'h18, 64'h0123456789ABCDEF);

    // Reset between AW handshake and W
    awaddr64 = 8'h18; awvalid64 = 1'b1;
    check("mid_awready", awready64, 1);
    tick();
    awvalid64 = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("mid_bvalid_rst", bvalid64, 0);
    check("mid_ready_rst", {awready64, wready64}, 2'b00);
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    tick();
    wdata64 = 64'hFFFF_FFFF_FFFF_FFFF; wstrb64 = 8'hFF; wvalid64 = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (wvalid64 && wready64) begin tick(); wvalid64 = 1'b0; end
      else tick();
      if (bvalid64) seen = 1;
    end
    wvalid64 = 1'b0;
    check("mid_no_bvalid", seen, 0);
    check("mid_reg3_zero", reg_out64[255:192], 64'h0);
    rd64(8'h18, 64'h0);
    check("mid_reg_out32", reg_out === exp_flat(), 1);
    rd32(8'h14);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
